// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and bit timing.
// Transmitter and receiver both import this package so their timing matches.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // 2-bit FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Clock cycles per serial bit; integer division truncates (10416 at 100 MHz / 9600)
    function automatic int calc_clks_per_bit(input int clk_frequency, input int baud_rate);
        return clk_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-running 0..clks_per_bit-1 counter with synchronous clear.
// bit_tick marks the last cycle of each bit period, so the FSM advances on the
// edge that closes the period and bit boundaries never drift.
module uart_baud_gen #(
    parameter int clks_per_bit = 16
) (
    input  logic clk_fpga,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int              CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(clks_per_bit - 1);

    logic [CNT_W-1:0] baud_cnt;

    // Count within the bit period, wrapping at the last cycle; clear parks it at 0
    always_ff @(posedge clk_fpga) begin
        if (reset || clear) begin
            baud_cnt <= '0;
        end else if (baud_cnt == LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (baud_cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// All outputs come straight from flops; their next values are computed from
// the FSM's next state so TxD/tx_busy change on the same edge as the state.
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int clk_frequency = 100000000,
    parameter int baud_rate     = 9600,
    parameter int clks_per_bit  = calc_clks_per_bit(clk_frequency, baud_rate)
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] shift_q;
    logic [2:0] bit_idx;
    logic       bit_tick;
    logic       baud_clear;
    logic       txd_d;
    logic       busy_d;
    logic       done_d;

    // Baud counter is held clear while idle so a new frame starts on a fresh period
    uart_baud_gen #(
        .clks_per_bit (clks_per_bit)
    ) u_baud (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    // State register
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each non-idle state lasts exactly one bit period per bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (tx_start) state_next = START;
            START: if (bit_tick) state_next = DATA;
            DATA:  if (bit_tick && bit_idx == LAST_BIT) state_next = STOP;
            STOP:  if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next line level, busy and done, all registered below
    always_comb begin
        baud_clear = (state == IDLE);
        busy_d     = (state_next != IDLE);
        done_d     = (state == STOP) && bit_tick;
        txd_d      = TxD;
        case (state)
            IDLE:  txd_d = !tx_start;
            START: if (bit_tick) txd_d = shift_q[0];
            // shift_q[1] becomes shift_q[0] on the same edge
            DATA:  if (bit_tick) txd_d = (bit_idx == LAST_BIT) ? 1'b1 : shift_q[1];
            STOP:  if (bit_tick) txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    // Datapath and output flops; tx_data is captured only on the accepting edge
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            shift_q <= '0;
            bit_idx <= '0;
            TxD     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            TxD     <= txd_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
            case (state)
                IDLE: begin
                    if (tx_start) shift_q <= tx_data;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (bit_tick) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1 at 16 clocks per bit: reset/idle, table of frames
// (back-to-back, ignored requests, held start), reset mid-frame, random frames.
module tb_uart_tx_8n1;

    localparam int CPB = 16;

    logic       clk_fpga = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       TxD;
    logic       tx_busy;
    logic       tx_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_fpga = ~clk_fpga;

    uart_tx_8n1 #(.clks_per_bit(CPB)) dut (
        .clk_fpga (clk_fpga),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .TxD      (TxD),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    // mode: 0 = single pulse, 1 = 0xFF pokes at cycles 20/60, 2 = start held high
    typedef struct {
        logic [7:0] data;
        int         mode;
        bit         chain;
        logic [9:0] slots;   // expected line level per bit slot, slot 0 = start bit
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, stop 1
    function automatic logic [9:0] model_slots(input logic [7:0] d);
        logic [9:0] s;
        s[0] = 1'b0;
        for (int i = 1; i <= 8; i++) s[i] = (d >> (i - 1)) & 8'h01;
        s[9] = 1'b1;
        return s;
    endfunction

    // Request d in the current (idle or done) cycle, check every frame cycle,
    // decode mid-bit samples, and stop in the cycle where tx_done should be high.
    task automatic frame(input logic [7:0] d, input int mode, input logic [9:0] slots);
        logic [7:0] got;
        int         slot;
        tx_start = 1'b1;
        tx_data  = d;
        step();
        got = '0;
        for (int k = 1; k <= 10 * CPB; k++) begin
            slot = (k - 1) / CPB;
            check($sformatf("line d=%02h k=%0d {TxD,busy,done}", d, k),
                  32'({TxD, tx_busy, tx_done}), 32'({slots[slot], 1'b1, 1'b0}));
            if (((k - 1) % CPB) == CPB / 2 && slot >= 1 && slot <= 8) got[slot-1] = TxD;
            case (mode)
                1: begin
                    tx_start = (k == 20 || k == 60);
                    tx_data  = tx_start ? 8'hFF : 8'($urandom);
                end
                2: begin
                    tx_start = 1'b1;
                    tx_data  = 8'($urandom);
                end
                default: begin
                    tx_start = 1'b0;
                    tx_data  = 8'($urandom);
                end
            endcase
            step();
        end
        check($sformatf("decoded byte d=%02h", d), 32'(got), 32'(d));
        check($sformatf("end of frame d=%02h {busy,done}", d), 32'({tx_busy, tx_done}), 32'(2'b01));
    endtask

    // Drop the request and confirm the line idles with no further tx_done
    task automatic idle(input int n);
        tx_start = 1'b0;
        for (int i = 0; i <= n; i++) begin
            step();
            check("idle {TxD,busy,done}", 32'({TxD, tx_busy, tx_done}), 32'(3'b100));
        end
    endtask

    initial begin
        logic [9:0] s;
        logic [7:0] d;
        int         m;

        tbl[0] = '{8'h55, 0, 1'b0, 10'b1010101010};
        tbl[1] = '{8'hA3, 0, 1'b1, 10'b1101000110};
        tbl[2] = '{8'h0F, 0, 1'b0, 10'b1000011110};
        tbl[3] = '{8'h81, 1, 1'b0, 10'b1100000010};
        tbl[4] = '{8'h00, 0, 1'b0, 10'b1000000000};
        tbl[5] = '{8'h7E, 2, 1'b1, 10'b1011111100};
        tbl[6] = '{8'hFF, 0, 1'b0, 10'b1111111110};

        // Reset state, then a long quiet idle
        reset = 1'b1;
        repeat (3) step();
        check("reset {TxD,busy,done}", 32'({TxD, tx_busy, tx_done}), 32'(3'b100));
        reset = 1'b0;
        idle(1000);

        // Table of frames; chained entries start in the tx_done cycle
        for (int i = 0; i < 7; i++) begin
            frame(tbl[i].data, tbl[i].mode, tbl[i].slots);
            if (!tbl[i].chain) idle(3);
        end

        // Reset during data bit 3 of 0xC4 abandons the frame without tx_done
        s        = model_slots(8'hC4);
        tx_start = 1'b1;
        tx_data  = 8'hC4;
        step();
        tx_start = 1'b0;
        for (int k = 1; k <= 4 * CPB + 5; k++) begin
            check($sformatf("pre-reset line k=%0d", k),
                  32'({TxD, tx_busy, tx_done}), 32'({s[(k-1)/CPB], 1'b1, 1'b0}));
            if (k == 4 * CPB + 5) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        check("after mid-frame reset {TxD,busy,done}", 32'({TxD, tx_busy, tx_done}), 32'(3'b100));
        idle(2 * CPB);
        frame(8'h3C, 0, 10'b1001111000);
        idle(3);

        // Random bytes, request styles and chaining against the reference frame
        for (int r = 0; r < 20; r++) begin
            d = 8'($urandom);
            m = int'($urandom_range(0, 2));
            frame(d, m, model_slots(d));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 4)));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
